mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-ported 64-bit data memory between the fetch stage (instruction requester) and the memory stage (data requester: mrmovq, rmmovq, pushq, popq, call, ret). Grants one access per cycle, serialises reads through a one-cycle memory read latency, and prevents fetch starvation with a bounded-priority counter. Sits between the fetch and memory stages and the memory array.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data requesters, with a one-cycle read return.
// Optional build macro MEM_ARB_ADDR_CHECK_EN: reject accesses whose 8-byte word runs past MEM_BYTES.
module mem_port_arbiter #(
    parameter int MEM_BYTES  = 4096,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [63:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    output logic        i_err,
    output logic        d_err
);

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [63:0] LAST_WORD  = 64'(MEM_BYTES - 8);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arbState_t;

    arbState_t   state;
    logic        rdOwner;
    logic [3:0]  starveCnt;

    logic        idleActive;
    logic        rdPhase;
    logic        fetchWins;
    logic        grantI;
    logic        grantD;
    logic        selWe;
    logic [63:0] selAddr;
    logic [63:0] selWdata;
    logic        addrBad;

    always_comb begin
        // Gating with rst_n keeps every output at 0 while reset is held.
        idleActive = rst_n && (state == IDLE);
        rdPhase    = rst_n && (state == RD_WAIT);
        fetchWins  = i_req && (!d_req || (starveCnt == STARVE_LIM));
        grantI     = idleActive && fetchWins;
        grantD     = idleActive && d_req && !fetchWins;
        selWe      = grantD && d_we;
        selAddr    = 64'd0;
        selWdata   = 64'd0;
        if (grantD) begin
            selAddr  = d_addr;
            selWdata = d_wdata;
        end else if (grantI) begin
            selAddr  = i_addr;
        end
        addrBad    = ADDR_CHECK && (grantI || grantD) && (selAddr > LAST_WORD);
    end

    always_comb begin
        i_gnt    = grantI;
        d_gnt    = grantD;
        m_en     = (grantI || grantD) && !addrBad;
        m_we     = selWe && !addrBad;
        m_addr   = selAddr;
        m_wdata  = selWdata;
        i_err    = grantI && addrBad;
        d_err    = grantD && addrBad;
        i_rvalid = rdPhase && !rdOwner;
        d_rvalid = rdPhase && rdOwner;
        i_rdata  = i_rvalid ? m_rdata : 64'd0;
        d_rdata  = d_rvalid ? m_rdata : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdOwner   <= 1'b0;
            starveCnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantI || !i_req) begin
                        starveCnt <= 4'd0;
                    end else if (grantD && (starveCnt != STARVE_LIM)) begin
                        starveCnt <= starveCnt + 4'd1;
                    end
                    // Rejected accesses never touch memory, so no read return to wait for.
                    if ((grantI || grantD) && !selWe && !addrBad) begin
                        state   <= RD_WAIT;
                        rdOwner <= grantD;
                    end
                end
                RD_WAIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic checked against a
// transaction-level model (grant rule, starvation streak, shadow memory of completed writes).
module tb_mem_port_arbiter;

    localparam int MEM_BYTES  = 4096;
    localparam int STARVE_MAX = 3;

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 8);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [63:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        i_err;
    logic        d_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_BYTES (MEM_BYTES),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .i_err   (i_err),
        .d_err   (d_err)
    );

    int nTests = 0;
    int nFails = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctlVec();
        return {i_gnt, d_gnt, m_en, m_we, i_rvalid, d_rvalid, i_err, d_err};
    endfunction

    function automatic logic [63:0] randAddr();
        if ($urandom_range(0, 7) == 0) return 64'(MEM_BYTES - 4);
        return 64'($urandom_range(0, 7)) << 3;
    endfunction

    // Random-phase state
    logic        iPend, dPend, dWeR;
    logic [63:0] iAddrR, dAddrR, dWdataR;
    logic [63:0] shadow [8];
    logic [63:0] memArr [8];
    logic [63:0] rdNext, busyAddr;
    logic        rdNextValid;
    int          busyOwner, streak;

    initial begin
        // Reset with both requesters asserted
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 64'h80; d_addr = 64'h40; d_wdata = 64'hDEAD_BEEF_0000_0001;
        m_rdata = 64'h5555_AAAA_5555_AAAA;
        repeat (2) begin
            @(negedge clk);
            checkEq("rst_ctl", 64'(ctlVec()), 64'd0);
            checkEq("rst_maddr", m_addr, 64'd0);
            checkEq("rst_mwdata", m_wdata, 64'd0);
            checkEq("rst_irdata", i_rdata, 64'd0);
            checkEq("rst_drdata", d_rdata, 64'd0);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkEq("rel_dgnt", 64'(d_gnt), 64'd1);
        checkEq("rel_ignt", 64'(i_gnt), 64'd0);
        checkEq("rel_maddr", m_addr, 64'h40);
        tick();
        i_req = 1'b0; d_req = 1'b0; m_rdata = 64'hA5A5_0000_1234_5678;
        @(negedge clk);
        checkEq("rel_drvalid", 64'(d_rvalid), 64'd1);
        checkEq("rel_drdata", d_rdata, 64'hA5A5_0000_1234_5678);
        tick();
        $display("[TB] reset: both requests held, data granted on release");

        // Single data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
        @(negedge clk);
        checkEq("rd_dgnt", 64'(d_gnt), 64'd1);
        checkEq("rd_men", 64'(m_en), 64'd1);
        checkEq("rd_mwe", 64'(m_we), 64'd0);
        checkEq("rd_maddr", m_addr, 64'h10);
        tick();
        d_req = 1'b0; m_rdata = 64'h1122_3344_5566_7788;
        @(negedge clk);
        checkEq("rd_drvalid", 64'(d_rvalid), 64'd1);
        checkEq("rd_drdata", d_rdata, 64'h1122_3344_5566_7788);
        checkEq("rd_irvalid", 64'(i_rvalid), 64'd0);
        checkEq("rd_irdata", i_rdata, 64'd0);
        checkEq("rd_wait_dgnt", 64'(d_gnt), 64'd0);
        checkEq("rd_wait_men", 64'(m_en), 64'd0);
        tick();
        $display("[TB] data read addr=0x10");

        // Back-to-back writes
        for (int k = 0; k < 3; k++) begin
            d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20 + 64'(8 * k);
            d_wdata = 64'hC0DE_0000_0000_0000 + 64'(k);
            @(negedge clk);
            checkEq("wr_dgnt", 64'(d_gnt), 64'd1);
            checkEq("wr_menwe", 64'(m_en && m_we), 64'd1);
            checkEq("wr_maddr", m_addr, 64'h20 + 64'(8 * k));
            checkEq("wr_mwdata", m_wdata, 64'hC0DE_0000_0000_0000 + 64'(k));
            $display("[TB] data write addr=%h", d_addr);
            tick();
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // Starvation bound with a continuous stream of data writes
        i_req = 1'b1; i_addr = 64'h100; d_req = 1'b1; d_we = 1'b1;
        for (int k = 0; k < STARVE_MAX; k++) begin
            d_addr = 64'(8 * k);
            @(negedge clk);
            checkEq("stv_dgnt", 64'(d_gnt), 64'd1);
            checkEq("stv_ignt", 64'(i_gnt), 64'd0);
            tick();
        end
        @(negedge clk);
        checkEq("stv_fetch_ignt", 64'(i_gnt), 64'd1);
        checkEq("stv_fetch_dgnt", 64'(d_gnt), 64'd0);
        checkEq("stv_fetch_maddr", m_addr, 64'h100);
        checkEq("stv_fetch_mwe", 64'(m_we), 64'd0);
        checkEq("stv_fetch_mwdata", m_wdata, 64'd0);
        tick();
        i_req = 1'b0; m_rdata = 64'h0F0F_1E1E_2D2D_3C3C;
        @(negedge clk);
        checkEq("stv_irvalid", 64'(i_rvalid), 64'd1);
        checkEq("stv_irdata", i_rdata, 64'h0F0F_1E1E_2D2D_3C3C);
        checkEq("stv_drdata", d_rdata, 64'd0);
        checkEq("stv_wait_dgnt", 64'(d_gnt), 64'd0);
        tick();
        @(negedge clk);
        checkEq("stv_resume_dgnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        $display("[TB] starvation: %0d data grants then fetch", STARVE_MAX);

        // Reset during the read-return cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h18;
        @(negedge clk);
        checkEq("rrd_dgnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 1'b0; rst_n = 1'b0; m_rdata = 64'h7777_8888_9999_AAAA;
        @(negedge clk);
        checkEq("rrd_drvalid", 64'(d_rvalid), 64'd0);
        checkEq("rrd_drdata", d_rdata, 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkEq("rrd_idle_ctl", 64'(ctlVec()), 64'd0);
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h28;
        @(negedge clk);
        checkEq("rrd_after_dgnt", 64'(d_gnt), 64'd1);
        checkEq("rrd_after_men", 64'(m_en), 64'd1);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        $display("[TB] reset during read return");

        // Address range boundary (word straddling the end of memory, and 64-bit wrap)
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'(MEM_BYTES - 7);
        @(negedge clk);
        checkEq("oob_dgnt", 64'(d_gnt), 64'd1);
        checkEq("oob_derr", 64'(d_err), ADDR_CHK ? 64'd1 : 64'd0);
        checkEq("oob_men", 64'(m_en), ADDR_CHK ? 64'd0 : 64'd1);
        tick();
        d_req = 1'b0; m_rdata = 64'h4242_4242_4242_4242;
        @(negedge clk);
        checkEq("oob_drvalid", 64'(d_rvalid), ADDR_CHK ? 64'd0 : 64'd1);
        checkEq("oob_derr_next", 64'(d_err), 64'd0);
        tick();
        d_req = 1'b1; d_addr = 64'(MEM_BYTES - 8);
        @(negedge clk);
        checkEq("edge_dgnt", 64'(d_gnt), 64'd1);
        checkEq("edge_derr", 64'(d_err), 64'd0);
        checkEq("edge_men", 64'(m_en), 64'd1);
        tick();
        d_req = 1'b0; m_rdata = 64'h6161_6161_6161_6161;
        @(negedge clk);
        checkEq("edge_drvalid", 64'(d_rvalid), 64'd1);
        checkEq("edge_drdata", d_rdata, 64'h6161_6161_6161_6161);
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        checkEq("wrap_derr", 64'(d_err), ADDR_CHK ? 64'd1 : 64'd0);
        checkEq("wrap_mwe", 64'(m_we), ADDR_CHK ? 64'd0 : 64'd1);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        $display("[TB] address boundary, check enabled=%0d", ADDR_CHK);

        // Random traffic against the transaction model
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        busyOwner = -1; streak = 0; rdNextValid = 1'b0; rdNext = 64'd0; busyAddr = 64'd0;
        iPend = 1'b0; dPend = 1'b0; dWeR = 1'b0;
        iAddrR = 64'd0; dAddrR = 64'd0; dWdataR = 64'd0;
        for (int i = 0; i < 8; i++) begin
            shadow[i] = 64'd0;
            memArr[i] = 64'd0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        eIg, eDg, eBad, eWe;
            logic [63:0] eAddr, eIr, eDr;
            logic [7:0]  eCtl;
            if (!iPend && $urandom_range(0, 99) < 50) begin
                iPend = 1'b1; iAddrR = randAddr();
            end
            if (!dPend && $urandom_range(0, 99) < 70) begin
                dPend = 1'b1; dWeR = 1'($urandom_range(0, 1));
                dAddrR = randAddr(); dWdataR = {$urandom, $urandom};
            end
            i_req = iPend; i_addr = iAddrR;
            d_req = dPend; d_we = dWeR; d_addr = dAddrR; d_wdata = dWdataR;
            m_rdata = rdNextValid ? rdNext : {$urandom, $urandom};
            @(negedge clk);

            eIg = 1'b0; eDg = 1'b0; eBad = 1'b0; eWe = 1'b0;
            eAddr = 64'd0; eIr = 64'd0; eDr = 64'd0;
            if (busyOwner == 0) eIr = shadow[busyAddr[5:3]];
            if (busyOwner == 1) eDr = shadow[busyAddr[5:3]];
            if (busyOwner < 0) begin
                if (iPend && (!dPend || streak >= STARVE_MAX)) begin
                    eIg = 1'b1; eAddr = iAddrR;
                end else if (dPend) begin
                    eDg = 1'b1; eAddr = dAddrR; eWe = dWeR;
                end
                eBad = ADDR_CHK && (eIg || eDg) && (eAddr > LAST_WORD);
            end
            eCtl = {eIg, eDg, (eIg || eDg) && !eBad, eWe && !eBad,
                    busyOwner == 0, busyOwner == 1, eIg && eBad, eDg && eBad};
            checkEq("rnd_ctl", 64'(ctlVec()), 64'(eCtl));
            checkEq("rnd_irdata", i_rdata, eIr);
            checkEq("rnd_drdata", d_rdata, eDr);
            if (eIg || eDg) checkEq("rnd_maddr", m_addr, eAddr);
            if (eDg && eWe && !eBad) checkEq("rnd_mwdata", m_wdata, dWdataR);

            // Memory responder: acts on what the DUT actually presented
            rdNextValid = m_en && !m_we;
            rdNext = memArr[m_addr[5:3]];
            if (m_en && m_we) memArr[m_addr[5:3]] = m_wdata;

            // Model update
            if (busyOwner >= 0) begin
                busyOwner = -1;
            end else begin
                if (eIg || !iPend) streak = 0;
                else if (eDg && streak < STARVE_MAX) streak++;
                if (eDg && eWe && !eBad) shadow[eAddr[5:3]] = dWdataR;
                if ((eIg || eDg) && !eWe && !eBad) begin
                    busyOwner = eDg ? 1 : 0;
                    busyAddr = eAddr;
                end
                if (eIg || eDg)
                    $display("[TB] cyc %0d %s %s addr=%h%s", cyc, eIg ? "fetch" : "data ",
                             eWe ? "wr" : "rd", eAddr, eBad ? " addr-err" : "");
                if (eIg) iPend = 1'b0;
                if (eDg) dPend = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
